fp_addsub_pipe: RTL and testbench

- Parametrised successor to the fixed-format 64-bit FP adder/subtracter.
- Generic IEEE-754 binary format selected by EXP_W/FRAC_W: fp16, fp32, fp64, fp128.
- Adds a valid/tag sideband pipeline, correct sticky generation, exception flags and an explicit 4-cycle latency.
- Output is the unnormalised extended result (carry, hidden, fraction, G/R/S); the existing normaliser/rounder downstream consumes it.

---
 rtl/fp_addsub_pipe_if.sv | 32 +++
 rtl/fp_addsub_pipe.sv | 187 ++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result bundle for fp_addsub_pipe: requester drives operands, the pipe returns
// the unnormalised sum with its tag and exception flags.
interface fp_addsub_pipe_if #(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52,
   parameter int TAG_W  = 4
);
   logic                    vld_i;
   logic [TAG_W-1:0]        tag_i;
   logic [2:0]              rm;
   logic                    op;
   logic [EXP_W+FRAC_W:0]   a;
   logic [EXP_W+FRAC_W:0]   b;
   logic                    vld_o;
   logic [TAG_W-1:0]        tag_o;
   logic                    so;
   logic [EXP_W-1:0]        xo;
   logic [FRAC_W+4:0]       mo;
   logic                    invalid_o;
   logic                    nan_o;
   logic                    inf_o;

   modport master (
      output vld_i, tag_i, rm, op, a, b,
      input  vld_o, tag_o, so, xo, mo, invalid_o, nan_o, inf_o
   );

   modport slave (
      input  vld_i, tag_i, rm, op, a, b,
      output vld_o, tag_o, so, xo, mo, invalid_o, nan_o, inf_o
   );
endinterface

// File: rtl/fp_addsub_pipe.sv
// IEEE add/subtract front half (decode, align, add, select): fixed 4 ce-cycle latency.
// No backpressure: one op accepted per ce cycle; ce=0 freezes every stage.
module fp_addsub_pipe #(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52,
   parameter int TAG_W  = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   fp_addsub_pipe_if.slave io
);
   localparam int SW = FRAC_W + 4;
   localparam int MW = FRAC_W + 5;
   localparam logic [EXP_W-1:0]  EXP_ONES = '1;
   localparam logic [EXP_W-1:0]  DMAX     = EXP_W'(SW);
   localparam logic [FRAC_W-1:0] QBIT     = FRAC_W'(1) << (FRAC_W - 1);

   typedef struct packed {
      logic              vld;
      logic [TAG_W-1:0]  tag;
      logic              rdn;
      logic              eff_sub;
      logic              sgn;
      logic [EXP_W-1:0]  xbig;
      logic              zero_add;
      logic              sp_nan;
      logic              sp_inf;
      logic              invalid;
      logic              sp_sgn;
      logic [FRAC_W-1:0] sp_frac;
   } ctl_t;

   typedef struct packed {
      logic [EXP_W-1:0] xsml;
      logic [FRAC_W:0]  sbig;
      logic [FRAC_W:0]  ssml;
   } op1_t;

   typedef struct packed {
      logic [SW-1:0] big;
      logic [SW-1:0] sml;
   } op2_t;

   typedef struct packed {
      logic              vld;
      logic [TAG_W-1:0]  tag;
      logic              so;
      logic [EXP_W-1:0]  xo;
      logic [MW-1:0]     mo;
      logic              invalid;
      logic              nan;
      logic              inf;
   } out_t;

   ctl_t          c1_d, c1_q, c2_d, c2_q, c3_d, c3_q;
   op1_t          p1_d, p1_q;
   op2_t          p2_d, p2_q;
   logic [MW-1:0] mag_d, mag_q;
   out_t          o_d, o_q;

   logic              sa, sb, hid_a, hid_b, a_ge_b, eff_sub;
   logic              a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
   logic [EXP_W-1:0]  ea, eb, xda, xdb, d, dc;
   logic [FRAC_W-1:0] fa, fb;
   logic [SW-1:0]     sml_ext, lost;

   always_comb begin
      sa      = io.a[EXP_W+FRAC_W];
      sb      = io.b[EXP_W+FRAC_W];
      ea      = io.a[EXP_W+FRAC_W-1:FRAC_W];
      eb      = io.b[EXP_W+FRAC_W-1:FRAC_W];
      fa      = io.a[FRAC_W-1:0];
      fb      = io.b[FRAC_W-1:0];
      hid_a   = (ea != '0);
      hid_b   = (eb != '0);
      xda     = ea | EXP_W'(!hid_a);
      xdb     = eb | EXP_W'(!hid_b);
      a_nan   = (ea == EXP_ONES) && (fa != '0);
      b_nan   = (eb == EXP_ONES) && (fb != '0);
      a_snan  = a_nan && !fa[FRAC_W-1];
      b_snan  = b_nan && !fb[FRAC_W-1];
      a_inf   = (ea == EXP_ONES) && (fa == '0);
      b_inf   = (eb == EXP_ONES) && (fb == '0);
      a_zero  = !hid_a && (fa == '0);
      b_zero  = !hid_b && (fb == '0);
      eff_sub = io.op ^ sa ^ sb;
      a_ge_b  = {xda, fa} >= {xdb, fb};

      c1_d          = '0;
      c1_d.vld      = io.vld_i;
      c1_d.tag      = io.tag_i;
      c1_d.rdn      = (io.rm == 3'd3);
      c1_d.eff_sub  = eff_sub;
      c1_d.sgn      = a_ge_b ? sa : (sb ^ io.op);
      c1_d.xbig     = a_ge_b ? xda : xdb;
      c1_d.zero_add = !eff_sub && a_zero && b_zero;
      c1_d.invalid  = a_snan || b_snan || (a_inf && b_inf && eff_sub);
      // Special-operand result is resolved here and simply travels down the pipe.
      if (a_nan || b_nan) begin
         c1_d.sp_nan  = 1'b1;
         c1_d.sp_sgn  = a_nan ? sa : sb;
         c1_d.sp_frac = (a_nan ? fa : fb) | QBIT;
      end else if (a_inf && b_inf && eff_sub) begin
         c1_d.sp_nan  = 1'b1;
         c1_d.sp_frac = QBIT;
      end else if (a_inf || b_inf) begin
         c1_d.sp_inf  = 1'b1;
         c1_d.sp_sgn  = a_inf ? sa : (sb ^ io.op);
      end

      p1_d.xsml = a_ge_b ? xdb : xda;
      p1_d.sbig = a_ge_b ? {hid_a, fa} : {hid_b, fb};
      p1_d.ssml = a_ge_b ? {hid_b, fb} : {hid_a, fa};
   end

   always_comb begin
      c2_d     = c1_q;
      d        = c1_q.xbig - p1_q.xsml;
      dc       = (d > DMAX) ? DMAX : d;
      sml_ext  = {p1_q.ssml, 3'b000};
      // Mask of every bit position the shift discards; full-width shift drops all of them.
      lost     = ~({SW{1'b1}} << dc);
      p2_d.big = {p1_q.sbig, 3'b000};
      p2_d.sml = (sml_ext >> dc) | SW'(|(sml_ext & lost));
   end

   always_comb begin
      c3_d  = c2_q;
      mag_d = c2_q.eff_sub ? ({1'b0, p2_q.big} - {1'b0, p2_q.sml})
                           : ({1'b0, p2_q.big} + {1'b0, p2_q.sml});
   end

   always_comb begin
      o_d     = '0;
      o_d.vld = c3_q.vld;
      o_d.tag = c3_q.tag;
      if (c3_q.sp_nan) begin
         o_d.so  = c3_q.sp_sgn;
         o_d.xo  = EXP_ONES;
         o_d.mo  = {2'b01, c3_q.sp_frac, 3'b000};
         o_d.nan = c3_q.vld;
      end else if (c3_q.sp_inf) begin
         o_d.so  = c3_q.sp_sgn;
         o_d.xo  = EXP_ONES;
         o_d.inf = c3_q.vld;
      end else if (c3_q.eff_sub && (mag_q == '0)) begin
         o_d.so  = c3_q.rdn;
      end else if (c3_q.zero_add) begin
         o_d.so  = c3_q.sgn;
      end else begin
         o_d.so  = c3_q.sgn;
         o_d.xo  = c3_q.xbig;
         o_d.mo  = mag_q;
      end
      o_d.invalid = c3_q.vld && c3_q.invalid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c1_q  <= '0;
         c2_q  <= '0;
         c3_q  <= '0;
         p1_q  <= '0;
         p2_q  <= '0;
         mag_q <= '0;
         o_q   <= '0;
      end else if (ce) begin
         c1_q  <= c1_d;
         c2_q  <= c2_d;
         c3_q  <= c3_d;
         p1_q  <= p1_d;
         p2_q  <= p2_d;
         mag_q <= mag_d;
         o_q   <= o_d;
      end
   end

   assign io.vld_o     = o_q.vld;
   assign io.tag_o     = o_q.tag;
   assign io.so        = o_q.so;
   assign io.xo        = o_q.xo;
   assign io.mo        = o_q.mo;
   assign io.invalid_o = o_q.invalid;
   assign io.nan_o     = o_q.nan;
   assign io.inf_o     = o_q.inf;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed checks of fp_addsub_pipe in fp64 and fp16 builds: arithmetic, specials,
// exact latency, clock-enable stalls and asynchronous reset of in-flight ops.
module tb_fp_addsub_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ce = 1'b0;

   always #5 clk = ~clk;

   fp_addsub_pipe_if #(.EXP_W(11), .FRAC_W(52), .TAG_W(4)) io64 ();
   fp_addsub_pipe_if #(.EXP_W(5),  .FRAC_W(10), .TAG_W(4)) io16 ();

   fp_addsub_pipe #(.EXP_W(11), .FRAC_W(52), .TAG_W(4)) u_dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .io    (io64.slave)
   );

   fp_addsub_pipe #(.EXP_W(5), .FRAC_W(10), .TAG_W(4)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .io    (io16.slave)
   );

   localparam logic [63:0] ONE   = 64'h3FF0000000000000;
   localparam logic [63:0] TWO   = 64'h4000000000000000;
   localparam logic [63:0] TINY  = 64'h3C30000000000000;
   localparam logic [63:0] PINF  = 64'h7FF0000000000000;
   localparam logic [63:0] SNAN  = 64'h7FF0000000000001;
   localparam logic [63:0] NZERO = 64'h8000000000000000;

   int n_cmp = 0;
   int n_err = 0;

   int         cnt = 0;
   logic       hv [0:63];
   logic [3:0] ht [0:63];
   logic       ev = 1'b0;
   logic [3:0] et = 4'h0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Issue one fp64 op at a negedge and land on the negedge where its result is due.
   task automatic run64(input logic [63:0] av, input logic [63:0] bv, input logic opv,
                        input logic [2:0] rmv, input logic [3:0] tg);
      io64.a     = av;
      io64.b     = bv;
      io64.op    = opv;
      io64.rm    = rmv;
      io64.tag_i = tg;
      io64.vld_i = 1'b1;
      @(negedge clk);
      io64.vld_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("lat_early", 128'(io64.vld_o), 0);
      @(negedge clk);
      chk("lat_vld", 128'(io64.vld_o), 1);
      chk("lat_tag", 128'(io64.tag_o), 128'(tg));
   endtask

   // One clock of the streaming test; the expected output is the input from 4 ce-cycles back.
   task automatic cyc(input logic cev, input logic vv, input logic [3:0] tg);
      ce         = cev;
      io64.vld_i = vv;
      io64.tag_i = tg;
      @(negedge clk);
      if (cev) begin
         hv[cnt] = vv;
         ht[cnt] = tg;
         cnt++;
         if (cnt >= 4) begin
            ev = hv[cnt-4];
            et = ht[cnt-4];
         end else begin
            ev = 1'b0;
         end
      end
      chk("strm_vld", 128'(io64.vld_o), 128'(ev));
      if (ev) chk("strm_tag", 128'(io64.tag_o), 128'(et));
   endtask

   initial begin
      io64.vld_i = 1'b0; io64.tag_i = '0; io64.rm = '0; io64.op = 1'b0;
      io64.a = '0; io64.b = '0;
      io16.vld_i = 1'b0; io16.tag_i = '0; io16.rm = '0; io16.op = 1'b0;
      io16.a = '0; io16.b = '0;
      ce = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_vld",   128'(io64.vld_o), 0);
      chk("rst_tag",   128'(io64.tag_o), 0);
      chk("rst_so",    128'(io64.so), 0);
      chk("rst_xo",    128'(io64.xo), 0);
      chk("rst_mo",    128'(io64.mo), 0);
      chk("rst_flags", 128'({io64.invalid_o, io64.nan_o, io64.inf_o}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run64(ONE, ONE, 1'b0, 3'd0, 4'h1);
      chk("add11_so",    128'(io64.so), 0);
      chk("add11_xo",    128'(io64.xo), 128'h3FF);
      chk("add11_mo",    128'(io64.mo), 128'd1 << 56);
      chk("add11_flags", 128'({io64.invalid_o, io64.nan_o, io64.inf_o}), 0);

      run64(ONE, ONE, 1'b1, 3'd0, 4'h2);
      chk("sub11_rne_so", 128'(io64.so), 0);
      chk("sub11_rne_xo", 128'(io64.xo), 0);
      chk("sub11_rne_mo", 128'(io64.mo), 0);

      run64(ONE, ONE, 1'b1, 3'd3, 4'h3);
      chk("sub11_rdn_so", 128'(io64.so), 1);
      chk("sub11_rdn_mo", 128'(io64.mo), 0);

      run64(ONE, TINY, 1'b0, 3'd0, 4'h4);
      chk("sticky_xo", 128'(io64.xo), 128'h3FF);
      chk("sticky_mo", 128'(io64.mo), (128'd1 << 55) | 128'd1);

      run64(ONE, TWO, 1'b1, 3'd0, 4'h5);
      chk("sub12_so", 128'(io64.so), 1);
      chk("sub12_xo", 128'(io64.xo), 128'h400);
      chk("sub12_mo", 128'(io64.mo), 128'd1 << 54);

      run64(NZERO, NZERO, 1'b0, 3'd0, 4'h6);
      chk("nz_add_so", 128'(io64.so), 1);
      chk("nz_add_xo", 128'(io64.xo), 0);
      chk("nz_add_mo", 128'(io64.mo), 0);

      run64(PINF, PINF, 1'b1, 3'd0, 4'h7);
      chk("infinf_flags", 128'({io64.invalid_o, io64.nan_o, io64.inf_o}), 128'b110);
      chk("infinf_so",    128'(io64.so), 0);
      chk("infinf_xo",    128'(io64.xo), 128'h7FF);
      chk("infinf_mo",    128'(io64.mo), (128'd1 << 55) | (128'd1 << 54));

      run64(PINF, ONE, 1'b0, 3'd0, 4'h8);
      chk("inf1_flags", 128'({io64.invalid_o, io64.nan_o, io64.inf_o}), 128'b001);
      chk("inf1_xo",    128'(io64.xo), 128'h7FF);
      chk("inf1_mo",    128'(io64.mo), 0);
      chk("inf1_so",    128'(io64.so), 0);

      run64(SNAN, ONE, 1'b0, 3'd0, 4'h9);
      chk("snan_flags", 128'({io64.invalid_o, io64.nan_o, io64.inf_o}), 128'b110);
      chk("snan_xo",    128'(io64.xo), 128'h7FF);
      chk("snan_frac",  128'(io64.mo[54:3]), 128'h8000000000001);
      chk("snan_top",   128'(io64.mo[56:55]), 128'b01);

      io64.a = ONE; io64.b = ONE; io64.op = 1'b0;
      cnt = 0;
      ev  = 1'b0;
      cyc(1'b1, 1'b1, 4'h1);
      cyc(1'b1, 1'b1, 4'h2);
      cyc(1'b1, 1'b1, 4'h3);
      cyc(1'b1, 1'b1, 4'h4);
      cyc(1'b1, 1'b1, 4'h5);
      cyc(1'b0, 1'b1, 4'hF);
      cyc(1'b0, 1'b0, 4'hE);
      cyc(1'b1, 1'b1, 4'h6);
      cyc(1'b1, 1'b0, 4'h0);
      cyc(1'b1, 1'b1, 4'h7);
      cyc(1'b1, 1'b1, 4'h8);
      cyc(1'b1, 1'b1, 4'h9);

      // Three ops are still in flight here; reset must drop them immediately.
      io64.vld_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_vld", 128'(io64.vld_o), 0);
      chk("arst_tag", 128'(io64.tag_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      ev  = 1'b0;
      cyc(1'b1, 1'b1, 4'hA);
      cyc(1'b1, 1'b0, 4'h0);
      cyc(1'b1, 1'b0, 4'h0);
      cyc(1'b1, 1'b0, 4'h0);
      cyc(1'b1, 1'b0, 4'h0);

      ce = 1'b1;
      io16.a = 16'h3C00; io16.b = 16'h3C00; io16.op = 1'b0; io16.rm = 3'd0;
      io16.tag_i = 4'h3;
      io16.vld_i = 1'b1;
      @(negedge clk);
      io16.vld_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("h_vld", 128'(io16.vld_o), 1);
      chk("h_tag", 128'(io16.tag_o), 3);
      chk("h_so",  128'(io16.so), 0);
      chk("h_xo",  128'(io16.xo), 15);
      chk("h_mo",  128'(io16.mo), 128'd1 << 14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
